elevator_call_scheduler: RTL

//   Call-scheduling controller for the elevator car. Latches floor calls into
//   a pending bitmap and serves them in SCAN order (keep direction while calls

---
 rtl/elevator_call_scheduler.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/elevator_call_scheduler.sv
// SCAN-order elevator call scheduler: latches floor calls, sequences the up/down
// motor drive with a per-floor travel timer, holds the door for a fixed dwell.
module elevator_call_scheduler #(
    parameter  int FLOORS        = 4,
    parameter  int TRAVEL_CYCLES = 8,
    parameter  int DOOR_CYCLES   = 4,
    localparam int FW            = $clog2(FLOORS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [FLOORS-1:0] call,
    output logic [FLOORS-1:0] pending,
    output logic [FW-1:0]     piso,
    output logic              motorsubir,
    output logic              motorbajar,
    output logic              door_open,
    output logic [6:0]        display
);

    localparam int TW = $clog2(TRAVEL_CYCLES + 1);
    localparam int DW = $clog2(DOOR_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        MOVE_UP,
        MOVE_DOWN,
        DOOR_OPEN
    } state_t;

    state_t            state_q, state_d;
    logic [FW-1:0]     piso_q, piso_d;
    logic [FLOORS-1:0] pending_q, pending_d;
    logic              dir_up_q, dir_up_d;
    logic [TW-1:0]     travel_q, travel_d;
    logic [DW-1:0]     door_q, door_d;
    logic              motorsubir_q, motorsubir_d;
    logic              motorbajar_q, motorbajar_d;
    logic              door_open_q, door_open_d;

    logic [FLOORS-1:0] call_eff;
    logic [FLOORS-1:0] served;
    logic [FW-1:0]     next_floor;
    logic              beyond;

    function automatic logic calls_above(input logic [FLOORS-1:0] p, input logic [FW-1:0] f);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < FLOORS; i++) begin
            if (i > int'(f) && p[i]) hit = 1'b1;
        end
        return hit;
    endfunction

    function automatic logic calls_below(input logic [FLOORS-1:0] p, input logic [FW-1:0] f);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < FLOORS; i++) begin
            if (i < int'(f) && p[i]) hit = 1'b1;
        end
        return hit;
    endfunction

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d    = state_q;
        piso_d     = piso_q;
        dir_up_d   = dir_up_q;
        travel_d   = travel_q;
        door_d     = door_q;
        served     = '0;
        next_floor = piso_q;
        beyond     = 1'b0;

        // A call for the floor whose door is already open is absorbed by this stop.
        call_eff = call;
        if (state_q == DOOR_OPEN) call_eff[piso_q] = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (pending_q[piso_q]) begin
                    state_d        = DOOR_OPEN;
                    door_d         = '0;
                    served[piso_q] = 1'b1;
                end else if (dir_up_q ? calls_above(pending_q, piso_q)
                                      : calls_below(pending_q, piso_q)) begin
                    state_d  = dir_up_q ? MOVE_UP : MOVE_DOWN;
                    travel_d = '0;
                end else if (dir_up_q ? calls_below(pending_q, piso_q)
                                      : calls_above(pending_q, piso_q)) begin
                    dir_up_d = ~dir_up_q;
                    state_d  = dir_up_q ? MOVE_DOWN : MOVE_UP;
                    travel_d = '0;
                end
            end
            MOVE_UP, MOVE_DOWN: begin
                if (travel_q == TW'(TRAVEL_CYCLES - 1)) begin
                    next_floor = (state_q == MOVE_UP) ? piso_q + 1'b1 : piso_q - 1'b1;
                    beyond     = (state_q == MOVE_UP) ? calls_above(pending_q, next_floor)
                                                      : calls_below(pending_q, next_floor);
                    piso_d     = next_floor;
                    if (pending_q[next_floor]) begin
                        state_d            = DOOR_OPEN;
                        door_d             = '0;
                        served[next_floor] = 1'b1;
                    end else if (beyond) begin
                        travel_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    travel_d = travel_q + 1'b1;
                end
            end
            DOOR_OPEN: begin
                if (door_q == DW'(DOOR_CYCLES - 1)) begin
                    state_d = IDLE;
                    door_d  = '0;
                end else begin
                    door_d = door_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Clearing on the stop edge wins over a same-edge call for that floor.
        pending_d    = (pending_q | call_eff) & ~served;
        motorsubir_d = (state_d == MOVE_UP);
        motorbajar_d = (state_d == MOVE_DOWN);
        door_open_d  = (state_d == DOOR_OPEN);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            piso_q       <= '0;
            pending_q    <= '0;
            dir_up_q     <= 1'b1;
            travel_q     <= '0;
            door_q       <= '0;
            motorsubir_q <= 1'b0;
            motorbajar_q <= 1'b0;
            door_open_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            piso_q       <= piso_d;
            pending_q    <= pending_d;
            dir_up_q     <= dir_up_d;
            travel_q     <= travel_d;
            door_q       <= door_d;
            motorsubir_q <= motorsubir_d;
            motorbajar_q <= motorbajar_d;
            door_open_q  <= door_open_d;
        end
    end

    // Segment order {g,f,e,d,c,b,a}; floor index n is shown as digit n+1.
    always_comb begin
        case (int'(piso_q))
            0:       display = 7'b0000110;
            1:       display = 7'b1011011;
            2:       display = 7'b1001111;
            3:       display = 7'b1100110;
            4:       display = 7'b1101101;
            5:       display = 7'b1111101;
            6:       display = 7'b0000111;
            7:       display = 7'b1111111;
            8:       display = 7'b1101111;
            default: display = 7'b0000000;
        endcase
    end

    assign pending    = pending_q;
    assign piso       = piso_q;
    assign motorsubir = motorsubir_q;
    assign motorbajar = motorbajar_q;
    assign door_open  = door_open_q;

endmodule
